scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//   Registered, parametrised one-hot decoder with a built-in index sequencer.
//   Drives digit/row selects for multiplexed displays and keypad scanning:
//   the index is either loaded from a select input (manual) or stepped
//   up/down at a prescaled rate over a programmable range 0..last.
//   The decoded one-hot output has optional active-low polarity.
// PARAMETERS
//   N          3  index width; output width M = 2**N (localparam)
//   DIV        4  clock cycles per scan step, >= 1 (DIV=1: step every cycle)
//   ACTIVE_LOW 0  1: selected output bit is 0 and inactive bits are 1
// PORTS
//   clk    in   1  single clock; all state updates on rising edge
//   rst_n  in   1  synchronous reset, active low
//   en     in   1  1: advance/update; 0: freeze all state and outputs
//   mode   in   2  00 OFF, 01 MANUAL, 10 SCAN_UP, 11 SCAN_DOWN
//   sel    in   N  index used in MANUAL mode
//   last   in   N  highest index in range; scan covers 0..last
//   out    out  M  registered one-hot (or one-cold) decode of idx
//   idx    out  N  current index register
//   wrap   out  1  one-cycle pulse on the edge where idx wraps
// BEHAVIOUR
//   Reset: rst_n sampled at clk edge only. idx=0, prescaler=0, wrap=0,
//     out = all inactive ({M{1'b0}}, or {M{1'b1}} if ACTIVE_LOW).
//     Reset overrides en and mode; asserting it mid-scan takes effect
//     on the next edge.
//   out is a function of registered state only: active bit = idx when mode!=OFF,
//     all inactive in OFF. It changes on the same edge as idx (no extra lag).
//   Prescaler: counts 0..DIV-1, only in SCAN modes with en=1. A step
//     fires on the edge where the count is DIV-1, and the count then returns to 0.
//     It is cleared in OFF and MANUAL. Switching UP<->DOWN keeps the count.
//   en=0: idx, prescaler and out hold; wrap=0. Resume continues the count.
//   OFF:    idx held, out inactive, wrap=0.
//   MANUAL: each edge idx <= (sel > last) ? last : sel. wrap=0.
//   SCAN_UP step:   idx <= (idx >= last) ? 0 : idx+1.
//     wrap=1 for one cycle when the new idx is 0 due to wrap.
//   SCAN_DOWN step: idx <= (idx == 0 || idx > last) ? last : idx-1.
//     wrap=1 when moving 0 -> last.
//   last=0: idx stays 0. Each step in SCAN modes pulses wrap.
//   last lowered below idx: no immediate change. Next step applies the rules above.
//   Entering SCAN from OFF/MANUAL: first step occurs DIV edges later.
//   Arithmetic is N-bit unsigned. No value of idx/out outside 0..M-1 can arise.
// TESTING
//   1 Reset: N=3, rst_n=0 for 2 edges -> out=8'h00, idx=0, wrap=0.
//     With ACTIVE_LOW=1 -> out=8'hFF.
//   2 Manual: mode=01, last=7, sel=5 -> next edge idx=5, out=8'b0010_0000.
//     Then last=4, sel=6 -> idx=4, out=8'b0001_0000.
//   3 Scan up: DIV=4, last=7, en=1 from reset -> out 01,02,04..80,01.
//     Each value holds 4 cycles. wrap=1 only on the edge of 80->01.
//   4 Scan down: last=5 from idx=0 -> idx 5 (wrap=1), 4,3,2,1,0,5 (wrap=1).
//     out[7:6] is never active.
//   5 Freeze: en=0 for 10 cycles mid-step (count=2) -> idx/out constant, wrap=0.
//     After en=1 the next step occurs 2 edges later.
//   6 Mid-scan reset: rst_n=0 at idx=6 -> next edge idx=0, out inactive.
//     After release in SCAN_UP, the first step occurs DIV edges later.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot (or one-cold) decoder with a built-in
// index sequencer. The index is loaded from sel (MANUAL) or stepped up/down
// at a prescaled rate over 0..last (SCAN_UP / SCAN_DOWN).
module scan_decoder #(
  parameter int N          = 3,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      sel,
  input  logic [N-1:0]      last,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int M  = 2**N;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [M-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    MANUAL    = 2'b01,
    SCAN_UP   = 2'b10,
    SCAN_DOWN = 2'b11
  } mode_t;

  mode_t           mode_e;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [N-1:0]    idx_nxt;
  logic            wrap_nxt;
  logic [M-1:0]    out_nxt;

  assign mode_e = mode_t'(mode);

  function automatic logic [M-1:0] decode(input logic [N-1:0] i);
    logic [M-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Next-state logic: prescaler, index sequencing and decode of the new index.
  // out is decoded from the next index so it updates on the same edge as idx.
  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    out_nxt  = out;
    if (en) begin
      case (mode_e)
        OFF: begin
          cnt_nxt = '0;
        end
        MANUAL: begin
          cnt_nxt = '0;
          idx_nxt = (sel > last) ? last : sel;
        end
        SCAN_UP: begin
          if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (idx >= last) begin
              idx_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx + N'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SCAN_DOWN: begin
          if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (idx == '0 || idx > last) begin
              idx_nxt  = last;
              wrap_nxt = (idx == '0);
            end else begin
              idx_nxt = idx - N'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
      out_nxt = (mode_e == OFF) ? INACTIVE : decode(idx_nxt);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
      out  <= INACTIVE;
    end else begin
      idx  <= idx_nxt;
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
      out  <= out_nxt;
    end
  end

endmodule
